// File: rtl/fetch_pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen_pkg
//   Shared types and constants for the front-end next-PC generator.
//
//   fetch_state_t : fetch sequencer state (BOOT / RUN / HALT)
//   fetch_pkt_t   : one packet handed to the fetch queue
//   FETCH_STRIDE  : byte distance between sequential fetch PCs
//   next_seq_pc() : sequential successor of a fetch PC (wraps at 2^32)
// ---------------------------------------------------------------------------
package fetch_pc_gen_pkg;

  // BOOT is the only state that reset can put us in; RUN generates PCs,
  // HALT lets the packet already in s1 drain but starts nothing new.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Everything the fetch queue needs for one fetch slot.
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_pkt_t;

  localparam logic [31:0] FETCH_STRIDE = 32'd4;

  // Plain 32-bit add: 32'hFFFF_FFFC rolls over to 32'h0000_0000 by design.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + FETCH_STRIDE;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//   Front-end next-PC generator sitting in front of the BTB.
//
//   A two-entry pipeline:
//     s0 : the PC currently presented on the BTB read port (btb_pc)
//     s1 : the PC whose packet is offered to the fetch queue
//   The BTB answers one cycle late, so the live btb_hit/btb_target belong to
//   s1 on the first cycle s1 holds a PC. That answer is captured so a stalled
//   packet keeps its prediction even after the BTB output moves on.
//
//   Next-PC priority: redirect > taken prediction on accept > PC+4 > hold.
//
// Ports
//   clk             in   clock, all state on posedge
//   rst_n           in   asynchronous active-low reset
//   fetch_en        in   1 = generate PCs, 0 = stop after current packet
//   btb_pc          out  [31:0] PC driven to the BTB read port
//   btb_hit         in   BTB hit for last cycle's btb_pc
//   btb_target      in   [31:0] BTB predicted target for that PC
//   redirect        in   backend flush / mispredict restart
//   redirect_pc     in   [31:0] restart PC
//   pkt_valid       out  packet valid toward the fetch queue
//   pkt_ready       in   fetch queue accepts the packet
//   pkt_pc          out  [31:0] packet PC
//   pkt_pred_taken  out  BTB predicted taken
//   pkt_pred_target out  [31:0] predicted target, zero when not taken
// ---------------------------------------------------------------------------
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] btb_pc,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [31:0] pkt_pc,
  output logic        pkt_pred_taken,
  output logic [31:0] pkt_pred_target
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  fetch_state_t state_q, state_d;

  logic [31:0] s0_pc_q, s0_pc_d;

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_pc_q,    s1_pc_d;
  logic        s1_fresh_q, s1_fresh_d;
  logic        s1_hit_q,   s1_hit_d;
  logic [31:0] s1_tgt_q,   s1_tgt_d;

  // ---------------------------------------------------------------------
  // Control terms
  // ---------------------------------------------------------------------
  logic        pred;
  logic [31:0] pred_tgt;
  logic        fire;
  logic        pred_redirect;
  logic        s1_free;
  logic        advance;
  fetch_pkt_t  pkt;

  // Pick the BTB answer that belongs to s1: the live port on the first
  // cycle s1 holds its PC, the captured copy while it sits stalled.
  // The target is trusted as-is; nothing checks it for alignment.
  always_comb begin
    pred     = s1_fresh_q ? btb_hit    : s1_hit_q;
    pred_tgt = s1_fresh_q ? btb_target : s1_tgt_q;
  end

  // A taken prediction only steers s0 once its packet is actually accepted;
  // the sequential PC already sitting in s0 is then on the wrong path and is
  // simply overwritten, costing one bubble.
  // s0 may move into s1 only while RUN is enabled and s1 is empty or leaving.
  // Neither s1_free nor advance feeds pkt_valid, so pkt_ready never reaches
  // pkt_valid combinationally.
  always_comb begin
    fire          = s1_valid_q & pkt_ready;
    pred_redirect = fire & pred;
    s1_free       = ~s1_valid_q | pkt_ready;
    advance       = (state_q == RUN) & fetch_en & s1_free &
                    ~redirect & ~pred_redirect;
  end

  // ---------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------
  // BOOT waits for the first enable. RUN drops to HALT the cycle enable
  // falls (advance is already blocked by fetch_en=0 that same cycle), and
  // HALT resumes on enable. Redirect never changes the state by itself.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = HALT;
      HALT:    if (fetch_en)  state_d = RUN;
      default:                state_d = BOOT;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next s0 PC
  // ---------------------------------------------------------------------
  // Redirect wins over everything, including a prediction that fires in
  // the same cycle. A prediction still steers s0 even if fetch is being
  // disabled or the sequencer is already in HALT.
  always_comb begin
    s0_pc_d = s0_pc_q;
    if (redirect) begin
      s0_pc_d = redirect_pc;
    end else if (pred_redirect) begin
      s0_pc_d = pred_tgt;
    end else if (advance) begin
      s0_pc_d = next_seq_pc(s0_pc_q);
    end
  end

  // ---------------------------------------------------------------------
  // Next s1 contents
  // ---------------------------------------------------------------------
  // s1_fresh is a one-cycle flag set only when s0 moves in. While it is
  // set the live BTB answer is copied into the hold registers, so from the
  // next cycle on the stalled packet reads its own prediction from there.
  // Redirect is the only way a packet leaves without being accepted; a
  // packet accepted in the same cycle as a redirect still counts as taken
  // by the queue, which is why dropping s1_valid is safe either way.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pc_d    = s1_pc_q;
    s1_fresh_d = 1'b0;
    s1_hit_d   = s1_hit_q;
    s1_tgt_d   = s1_tgt_q;

    if (s1_fresh_q) begin
      s1_hit_d = btb_hit;
      s1_tgt_d = btb_target;
    end

    if (redirect) begin
      s1_valid_d = 1'b0;
    end else if (advance) begin
      s1_valid_d = 1'b1;
      s1_pc_d    = s0_pc_q;
      s1_fresh_d = 1'b1;
    end else if (fire) begin
      s1_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // Reset can land at any time, including mid-stall; the packet in s1 is
  // discarded and fetch restarts from RESET_PC once enabled again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      s0_pc_q    <= RESET_PC;
      s1_valid_q <= 1'b0;
      s1_pc_q    <= 32'h0;
      s1_fresh_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_tgt_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      s0_pc_q    <= s0_pc_d;
      s1_valid_q <= s1_valid_d;
      s1_pc_q    <= s1_pc_d;
      s1_fresh_q <= s1_fresh_d;
      s1_hit_q   <= s1_hit_d;
      s1_tgt_q   <= s1_tgt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The prediction fields are qualified with s1_valid so an empty slot
  // always shows a clean not-taken / zero-target packet. During a stall
  // every field comes from s1 registers, so they hold steady until accept
  // or redirect.
  always_comb begin
    pkt.pc          = s1_pc_q;
    pkt.pred_taken  = s1_valid_q & pred;
    pkt.pred_target = pkt.pred_taken ? pred_tgt : 32'h0;
  end

  assign btb_pc          = s0_pc_q;
  assign pkt_valid       = s1_valid_q;
  assign pkt_pc          = pkt.pc;
  assign pkt_pred_taken  = pkt.pred_taken;
  assign pkt_pred_target = pkt.pred_target;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_gen
//   Directed bench for fetch_pc_gen. A tiny BTB model answers one cycle late
//   for a single programmable hit PC; inputs change and outputs are sampled
//   just after the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] btb_pc;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [31:0] pkt_pc;
  logic        pkt_pred_taken;
  logic [31:0] pkt_pred_target;

  int checkCount = 0;
  int passCount  = 0;

  // BTB model configuration
  logic [31:0] hitPc      = 32'h0000_0001;
  logic [31:0] hitTarget  = 32'h6000_0100;
  logic        btbKill    = 1'b0;
  logic [31:0] prevBtbPc  = 32'h0;

  fetch_pc_gen #(.RESET_PC(32'h6000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .btb_pc          (btb_pc),
    .btb_hit         (btb_hit),
    .btb_target      (btb_target),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .pkt_valid       (pkt_valid),
    .pkt_ready       (pkt_ready),
    .pkt_pc          (pkt_pc),
    .pkt_pred_taken  (pkt_pred_taken),
    .pkt_pred_target (pkt_pred_target)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance one cycle: drive the BTB answer for last cycle's btb_pc at the
  // falling edge, then let combinational outputs settle before sampling.
  task automatic applyStimulus();
    @(negedge clk);
    if (btbKill) begin
      btb_hit    = 1'b0;
      btb_target = 32'hDEAD_BEEF;
    end else if (prevBtbPc == hitPc) begin
      btb_hit    = 1'b1;
      btb_target = hitTarget;
    end else begin
      btb_hit    = 1'b0;
      btb_target = 32'h0;
    end
    prevBtbPc = btb_pc;
    #1;
  endtask

  // Step until a packet shows up, bounded.
  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!pkt_valid && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, {31'b0, pkt_valid}, 32'd1);
  endtask

  task automatic checkPkt(input string tag, input logic [31:0] pc,
                          input logic taken, input logic [31:0] tgt);
    checkOutput({tag, "_valid"},  {31'b0, pkt_valid},      32'd1);
    checkOutput({tag, "_pc"},     pkt_pc,                  pc);
    checkOutput({tag, "_taken"},  {31'b0, pkt_pred_taken}, {31'b0, taken});
    checkOutput({tag, "_target"}, pkt_pred_target,         tgt);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b1;
    fetch_en    = 1'b0;
    btb_hit     = 1'b0;
    btb_target  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    pkt_ready   = 1'b0;
    #2 rst_n = 1'b0;

    // Reset state
    @(negedge clk); #1;
    checkOutput("rst_btb_pc",    btb_pc,                  32'h6000_0000);
    checkOutput("rst_valid",     {31'b0, pkt_valid},      32'd0);
    checkOutput("rst_pc",        pkt_pc,                  32'h0);
    checkOutput("rst_taken",     {31'b0, pkt_pred_taken}, 32'd0);
    checkOutput("rst_target",    pkt_pred_target,         32'h0);

    // Test 1: sequential fetch, no hits
    @(negedge clk);
    rst_n = 1'b1; fetch_en = 1'b1; pkt_ready = 1'b1;
    waitValid("t1_first");
    checkPkt("t1_p0", 32'h6000_0000, 1'b0, 32'h0);
    applyStimulus(); checkPkt("t1_p1", 32'h6000_0004, 1'b0, 32'h0);
    applyStimulus(); checkPkt("t1_p2", 32'h6000_0008, 1'b0, 32'h0);
    checkOutput("t1_btb_pc", btb_pc, 32'h6000_000C);

    // Test 2: hit on 6000_0004 -> one bubble, then the target
    rst_n = 1'b0; #1; rst_n = 1'b1;
    hitPc = 32'h6000_0004;
    waitValid("t2_first");
    checkPkt("t2_p0", 32'h6000_0000, 1'b0, 32'h0);
    applyStimulus(); checkPkt("t2_hit", 32'h6000_0004, 1'b1, 32'h6000_0100);
    applyStimulus();
    checkOutput("t2_bubble", {31'b0, pkt_valid}, 32'd0);
    checkOutput("t2_btb_pc", btb_pc, 32'h6000_0100);
    applyStimulus(); checkPkt("t2_tgt", 32'h6000_0100, 1'b0, 32'h0);

    // Test 3: re-fetch 6000_0004 via redirect, stall the hit packet
    redirect = 1'b1; redirect_pc = 32'h6000_0004;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("t3_drop", {31'b0, pkt_valid}, 32'd0);
    applyStimulus(); checkPkt("t3_hit", 32'h6000_0004, 1'b1, 32'h6000_0100);
    pkt_ready = 1'b0; btbKill = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkPkt($sformatf("t3_stall%0d", i), 32'h6000_0004, 1'b1, 32'h6000_0100);
    end
    pkt_ready = 1'b1; btbKill = 1'b0;
    applyStimulus();
    checkOutput("t3_bubble", {31'b0, pkt_valid}, 32'd0);
    checkOutput("t3_btb_pc", btb_pc, 32'h6000_0100);
    applyStimulus(); checkPkt("t3_tgt", 32'h6000_0100, 1'b0, 32'h0);

    // Test 4: redirect while stalled
    pkt_ready = 1'b0;
    applyStimulus(); checkPkt("t4_held", 32'h6000_0100, 1'b0, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h6000_2000;
    applyStimulus();
    redirect = 1'b0; pkt_ready = 1'b1;
    checkOutput("t4_drop", {31'b0, pkt_valid}, 32'd0);
    checkOutput("t4_btb_pc", btb_pc, 32'h6000_2000);
    applyStimulus(); checkPkt("t4_new", 32'h6000_2000, 1'b0, 32'h0);

    // Test 5: 32-bit wrap, redirect coinciding with an accept
    hitPc = 32'h0000_0001;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("t5_drop", {31'b0, pkt_valid}, 32'd0);
    applyStimulus(); checkPkt("t5_p0", 32'hFFFF_FFF8, 1'b0, 32'h0);
    applyStimulus(); checkPkt("t5_p1", 32'hFFFF_FFFC, 1'b0, 32'h0);
    checkOutput("t5_btb_wrap", btb_pc, 32'h0);
    applyStimulus(); checkPkt("t5_p2", 32'h0000_0000, 1'b0, 32'h0);
    checkOutput("t5_btb_pc", btb_pc, 32'h0000_0004);

    // Test 6: async reset mid-stall, then fetch_en gating
    pkt_ready = 1'b0;
    applyStimulus(); checkPkt("t6_stall", 32'h0000_0000, 1'b0, 32'h0);
    rst_n = 1'b0; fetch_en = 1'b0;
    #1;
    checkOutput("t6_rst_valid",  {31'b0, pkt_valid}, 32'd0);
    checkOutput("t6_rst_pc",     pkt_pc,             32'h0);
    checkOutput("t6_rst_btb_pc", btb_pc,             32'h6000_0000);
    @(negedge clk);
    rst_n = 1'b1; pkt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("t6_boot_idle%0d", i), {31'b0, pkt_valid}, 32'd0);
    end
    fetch_en = 1'b1;
    waitValid("t6_first");
    checkPkt("t6_p0", 32'h6000_0000, 1'b0, 32'h0);
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("t6_halt_valid%0d", i), {31'b0, pkt_valid}, 32'd0);
      checkOutput($sformatf("t6_halt_btb%0d", i), btb_pc, 32'h6000_0004);
    end
    fetch_en = 1'b1;
    waitValid("t6_resume");
    checkPkt("t6_p1", 32'h6000_0004, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
